// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared encoder types and constants for the position tracker and PWM reader
package encoder_pkg;

    localparam int K_NSTEP_PERIOD_DEFAULT = 400;
    localparam int K_ENC_POS_W            = 12;

    typedef logic [2:0] enc_state_t;

    localparam enc_state_t ST_IDLE      = 3'd0;
    localparam enc_state_t ST_INIT      = 3'd1;
    localparam enc_state_t ST_WAIT_TICK = 3'd2;
    localparam enc_state_t ST_REQUEST   = 3'd3;
    localparam enc_state_t ST_UPDATE    = 3'd4;

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable down-counter raising a done strobe on its last enabled cycle
module pulse_timer #(
    parameter int K_WIDTH = 17
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [K_WIDTH-1:0] i_load_val,
    input  logic               i_en,
    output logic               o_done
);

    logic [K_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // A load value of N yields done in the Nth enabled cycle after loading.
    assign o_done = i_en && (r_cnt <= K_WIDTH'(1));

endmodule

// File: rtl/encoder_pos_tracker.sv
// rtl/encoder_pos_tracker.sv - multi-turn position tracker driving a PWM encoder reader
module encoder_pos_tracker
    import encoder_pkg::*;
#(
    parameter int K_NSTEP_PERIOD  = K_NSTEP_PERIOD_DEFAULT,
    parameter int K_TURN_WIDTH    = 16,
    parameter int K_SAMPLE_PERIOD = 20000,
    parameter int K_TIMEOUT       = 100000
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_enable,
    input  logic [11:0]                    i_enc_pos,
    input  logic                           i_enc_valid,
    output logic                           o_enc_start,
    output logic                           o_enc_clear,
    output logic [11:0]                    o_angle,
    output logic signed [K_TURN_WIDTH-1:0] o_turns,
    output logic signed [12:0]             o_delta,
    output logic                           o_pos_valid,
    output logic                           o_init_done,
    output logic                           o_timeout,
    output logic                           o_range_err
);

    localparam int K_CNT_MAX = (K_TIMEOUT > K_SAMPLE_PERIOD) ? K_TIMEOUT : K_SAMPLE_PERIOD;
    localparam int K_CNT_W   = $clog2(K_CNT_MAX + 1);

    localparam logic [K_CNT_W-1:0]          K_LOAD_TICK = K_CNT_W'(K_SAMPLE_PERIOD - 1);
    localparam logic [K_CNT_W-1:0]          K_LOAD_TMO  = K_CNT_W'(K_TIMEOUT);
    localparam logic [12:0]                 K_NSTEP_U   = 13'(K_NSTEP_PERIOD);
    localparam logic signed [12:0]          K_NSTEP_S   = 13'(K_NSTEP_PERIOD);
    localparam logic signed [12:0]          K_HALF_S    = 13'(K_NSTEP_PERIOD / 2);
    localparam logic signed [K_TURN_WIDTH-1:0] K_TURN_ONE = {{(K_TURN_WIDTH-1){1'b0}}, 1'b1};

    enc_state_t                    r_state;
    enc_state_t                    w_next;
    logic                          r_enc_start;
    logic                          r_enc_clear;
    logic [11:0]                   r_angle;
    logic signed [K_TURN_WIDTH-1:0] r_turns;
    logic signed [12:0]            r_delta;
    logic                          r_pos_valid;
    logic                          r_init_done;
    logic                          r_timeout;
    logic                          r_range_err;

    logic                          w_wait_state;
    logic                          w_in_range;
    logic                          w_timer_done;
    logic                          w_timer_en;
    logic                          w_timed_out;
    logic                          w_enter;
    logic [K_CNT_W-1:0]            w_load_val;
    logic signed [12:0]            w_raw;
    logic signed [12:0]            w_delta;
    logic signed [K_TURN_WIDTH-1:0] w_turns_next;

    assign w_wait_state = (r_state == ST_INIT) || (r_state == ST_REQUEST);
    assign w_in_range   = {1'b0, i_enc_pos} < K_NSTEP_U;
    assign w_timed_out  = w_wait_state && w_timer_done && !i_enc_valid;
    assign w_timer_en   = w_wait_state || (r_state == ST_WAIT_TICK);

    // A timeout in INIT re-enters INIT, which must re-issue the clear pulse.
    assign w_enter    = i_enable && ((w_next != r_state) || w_timed_out);
    assign w_load_val = (w_next == ST_WAIT_TICK) ? K_LOAD_TICK : K_LOAD_TMO;

    pulse_timer #(
        .K_WIDTH (K_CNT_W)
    ) u_pulse_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_enter),
        .i_load_val (w_load_val),
        .i_en       (w_timer_en),
        .o_done     (w_timer_done)
    );

    always_comb begin
        w_next = r_state;
        if (!i_enable) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_next = ST_INIT;
                ST_INIT: begin
                    if (i_enc_valid && w_in_range) w_next = ST_WAIT_TICK;
                    else if (w_timed_out)          w_next = ST_INIT;
                end
                ST_WAIT_TICK: if (w_timer_done) w_next = ST_REQUEST;
                ST_REQUEST: begin
                    if (i_enc_valid)      w_next = w_in_range ? ST_UPDATE : ST_WAIT_TICK;
                    else if (w_timed_out) w_next = ST_INIT;
                end
                ST_UPDATE:    w_next = ST_WAIT_TICK;
                default:      w_next = ST_IDLE;
            endcase
        end
    end

    // Shortest-path unwrap; a step of exactly half a turn is taken as no wrap.
    assign w_raw = $signed({1'b0, i_enc_pos}) - $signed({1'b0, r_angle});

    always_comb begin
        w_delta      = w_raw;
        w_turns_next = r_turns;
        if (w_raw > K_HALF_S) begin
            w_delta      = w_raw - K_NSTEP_S;
            w_turns_next = r_turns - K_TURN_ONE;
        end else if (w_raw < -K_HALF_S) begin
            w_delta      = w_raw + K_NSTEP_S;
            w_turns_next = r_turns + K_TURN_ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_enc_start <= 1'b0;
            r_enc_clear <= 1'b0;
            r_angle     <= '0;
            r_turns     <= '0;
            r_delta     <= '0;
            r_pos_valid <= 1'b0;
            r_init_done <= 1'b0;
            r_timeout   <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_enc_clear <= w_enter && (w_next == ST_INIT);
            r_enc_start <= w_enter && (w_next == ST_REQUEST);
            r_pos_valid <= 1'b0;
            r_timeout   <= i_enable && w_timed_out;
            r_range_err <= i_enable && w_wait_state && i_enc_valid && !w_in_range;

            if (!i_enable || w_timed_out) begin
                r_init_done <= 1'b0;
            end else if ((r_state == ST_INIT) && i_enc_valid && w_in_range) begin
                r_angle     <= i_enc_pos;
                r_turns     <= '0;
                r_delta     <= '0;
                r_init_done <= 1'b1;
            end

            if (i_enable && (r_state == ST_REQUEST) && i_enc_valid && w_in_range) begin
                r_angle     <= i_enc_pos;
                r_turns     <= w_turns_next;
                r_delta     <= w_delta;
                r_pos_valid <= 1'b1;
            end
        end
    end

    assign o_enc_start = r_enc_start;
    assign o_enc_clear = r_enc_clear;
    assign o_angle     = r_angle;
    assign o_turns     = r_turns;
    assign o_delta     = r_delta;
    assign o_pos_valid = r_pos_valid;
    assign o_init_done = r_init_done;
    assign o_timeout   = r_timeout;
    assign o_range_err = r_range_err;

endmodule

// File: tb/tb_encoder_pos_tracker.sv
// tb/tb_encoder_pos_tracker.sv - directed self-checking bench for encoder_pos_tracker
module tb_encoder_pos_tracker;

    localparam int NSTEP  = 400;
    localparam int SAMPLE = 20;
    localparam int TMO    = 50;
    localparam int LIMIT  = 300;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [11:0]        pos;
    logic               valid;
    logic               enc_start;
    logic               enc_clear;
    logic [11:0]        angle;
    logic signed [15:0] turns;
    logic signed [12:0] delta;
    logic               pos_valid;
    logic               init_done;
    logic               timeout;
    logic               range_err;

    int n_checks = 0;
    int n_errors = 0;
    int n;
    logic seen;

    always #5 clk = ~clk;

    encoder_pos_tracker #(
        .K_NSTEP_PERIOD  (NSTEP),
        .K_TURN_WIDTH    (16),
        .K_SAMPLE_PERIOD (SAMPLE),
        .K_TIMEOUT       (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (en),
        .i_enc_pos   (pos),
        .i_enc_valid (valid),
        .o_enc_start (enc_start),
        .o_enc_clear (enc_clear),
        .o_angle     (angle),
        .o_turns     (turns),
        .o_delta     (delta),
        .o_pos_valid (pos_valid),
        .o_init_done (init_done),
        .o_timeout   (timeout),
        .o_range_err (range_err)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output int cnt);
        cnt = 0;
        while (!enc_start && cnt < LIMIT) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (!enc_clear && cnt < LIMIT) begin
            step();
            cnt++;
        end
    endtask

    task automatic deliver(input logic [11:0] p);
        pos   = p;
        valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},     enc_start, 0);
        check({tag, "_clear"},     enc_clear, 0);
        check({tag, "_angle"},     angle,     0);
        check({tag, "_turns"},     turns,     0);
        check({tag, "_delta"},     delta,     0);
        check({tag, "_pos_valid"}, pos_valid, 0);
        check({tag, "_init_done"}, init_done, 0);
        check({tag, "_timeout"},   timeout,   0);
        check({tag, "_range_err"}, range_err, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        valid = 1'b0;
        pos   = '0;
        step();
        step();
        check_all_zero("reset");

        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | enc_clear;
        end
        check("no_clear_while_disabled", seen, 0);

        en = 1'b1;
        wait_clear(n);
        check("init_clear_seen", enc_clear, 1);
        check("init_clear_latency", n, 1);
        check("init_no_start", enc_start, 0);
        step();
        check("init_clear_single", enc_clear, 0);

        deliver(12'd100);
        check("ref_init_done", init_done, 1);
        check("ref_angle", angle, 100);
        check("ref_turns", turns, 0);
        check("ref_no_pos_valid", pos_valid, 0);

        wait_start(n);
        check("first_start_latency", n, SAMPLE - 1);
        check("first_start_no_clear", enc_clear, 0);
        deliver(12'd390);
        check("u390_pos_valid", pos_valid, 1);
        check("u390_delta", delta, -110);
        check("u390_turns", turns, -1);
        check("u390_angle", angle, 390);
        step();
        check("u390_pos_valid_single", pos_valid, 0);

        wait_start(n);
        check("u10_start_seen", enc_start, 1);
        deliver(12'd10);
        check("u10_delta", delta, 20);
        check("u10_turns", turns, 0);
        check("u10_pos_valid", pos_valid, 1);

        en = 1'b0;
        step();
        step();
        check("dis_init_done", init_done, 0);
        check("dis_angle_hold", angle, 10);
        check("dis_delta_hold", delta, 20);
        check("dis_no_clear", enc_clear, 0);

        en = 1'b1;
        wait_clear(n);
        check("reen_clear", enc_clear, 1);
        step();
        deliver(12'd0);
        check("ref0_angle", angle, 0);
        check("ref0_init_done", init_done, 1);

        wait_start(n);
        deliver(12'd200);
        check("u200_delta", delta, 200);
        check("u200_turns", turns, 0);
        wait_start(n);
        deliver(12'd399);
        check("u399_delta", delta, 199);
        check("u399_turns", turns, 0);
        wait_start(n);
        deliver(12'd199);
        check("u199_delta", delta, -200);
        check("u199_turns", turns, 0);

        wait_start(n);
        deliver(12'd450);
        check("rng_err", range_err, 1);
        check("rng_no_pos_valid", pos_valid, 0);
        check("rng_angle_hold", angle, 199);
        check("rng_delta_hold", delta, -200);
        step();
        check("rng_err_single", range_err, 0);
        n = 2;
        while (!enc_start && n < LIMIT) begin
            step();
            n++;
        end
        check("rng_next_start", n, SAMPLE);

        n = 0;
        while (!timeout && n < LIMIT) begin
            step();
            n++;
        end
        check("tmo_seen", timeout, 1);
        check("tmo_latency", n, TMO);
        check("tmo_clear", enc_clear, 1);
        check("tmo_init_done", init_done, 0);
        check("tmo_no_start", enc_start, 0);
        step();
        check("tmo_single", timeout, 0);
        deliver(12'd300);
        check("tmo_reref_angle", angle, 300);
        check("tmo_reref_init_done", init_done, 1);

        wait_start(n);
        check("pre_rst_start", enc_start, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        en = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check_all_zero("post_rst_disabled");

        en = 1'b1;
        wait_clear(n);
        check("post_rst_clear", enc_clear, 1);
        check("post_rst_clear_latency", n, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
